// File: rtl/cmp_pkg.sv
// Shared types and constants for the streamed word comparator.
// Relation codes are what the top level latches per word pair.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_GT = 2'd1;
    localparam logic [1:0] RES_LT = 2'd2;

    localparam logic ORDER_MSW = 1'b0;
    localparam logic ORDER_LSW = 1'b1;

    function automatic logic [1:0] encode_rel(input logic gt, input logic lt);
        if (gt)
            return RES_GT;
        else if (lt)
            return RES_LT;
        else
            return RES_EQ;
    endfunction

endpackage

// File: rtl/word_cmp.sv
// Combinational unsigned compare of one word pair; the parametrised
// form of the single-bit comparator.
module word_cmp #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              eq,
    output logic              gt,
    output logic              lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_word_comparator.sv
// Multi-word unsigned comparator fed one word pair per cycle, with a
// start/valid/ready handshake and a registered eq/gt/lt result.
module seq_word_comparator
    import cmp_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              lsw_first,
    input  logic [WORD_W-1:0] a_word,
    input  logic [WORD_W-1:0] b_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              eq,
    output logic              gt,
    output logic              lt
);

    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] word_cnt;
    logic             order;
    logic             decided;
    logic [1:0]       rel;
    logic [1:0]       rel_next;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;
    logic             w_eq;
    logic             w_gt;
    logic             w_lt;
    logic             accept;
    logic             start_ok;
    logic             last_pair;

    word_cmp #(.WORD_W(WORD_W)) u_word_cmp (
        .a  (a_word),
        .b  (b_word),
        .eq (w_eq),
        .gt (w_gt),
        .lt (w_lt)
    );

    assign accept    = (state == COMPARE) && in_valid;
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign last_pair = accept && (word_cnt == LAST_IDX);

    // MSW-first keeps the first difference; LSW-first lets each later
    // (more significant) difference overwrite the earlier one.
    always_comb begin
        rel_next = rel;
        if (accept && !w_eq) begin
            if ((order == ORDER_LSW) || !decided)
                rel_next = encode_rel(w_gt, w_lt);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COMPARE;
            COMPARE: if (last_pair) state_next = DONE;
            DONE:    state_next = start ? COMPARE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_cnt <= '0;
            order    <= ORDER_MSW;
            decided  <= 1'b0;
            rel      <= RES_EQ;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                word_cnt <= '0;
                order    <= lsw_first;
                decided  <= 1'b0;
                rel      <= RES_EQ;
                eq_q     <= 1'b0;
                gt_q     <= 1'b0;
                lt_q     <= 1'b0;
            end else if (accept) begin
                rel <= rel_next;
                if (!w_eq)
                    decided <= 1'b1;
                if (last_pair) begin
                    eq_q <= (rel_next == RES_EQ);
                    gt_q <= (rel_next == RES_GT);
                    lt_q <= (rel_next == RES_LT);
                end else begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready = (state == COMPARE);
    assign busy     = (state == COMPARE);
    assign done     = (state == DONE);
    assign eq       = eq_q;
    assign gt       = gt_q;
    assign lt       = lt_q;

endmodule

// File: tb/tb_seq_word_comparator.sv
// Self-checking bench for seq_word_comparator: directed vector table,
// chained and reset sequences, and random compares against a 256-bit model.
module tb_seq_word_comparator;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int OP_W      = WORD_W * NUM_WORDS;

    typedef struct {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        bit              lsw;
        int              gap_start;
        int              gap_len;
        logic [2:0]      exp_res;
        int              exp_done;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              lsw_first = 1'b0;
    logic [WORD_W-1:0] a_word = '0;
    logic [WORD_W-1:0] b_word = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, busy, done, eq, gt, lt;

    logic              start1 = 1'b0;
    logic              lsw1 = 1'b0;
    logic [WORD_W-1:0] a1 = '0;
    logic [WORD_W-1:0] b1 = '0;
    logic              valid1 = 1'b0;
    logic              ready1, busy1, done1, eq1, gt1, lt1;

    int checks = 0;
    int failures = 0;
    bit pre_started = 0;

    always #5 clk = ~clk;

    seq_word_comparator #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lsw_first(lsw_first),
        .a_word(a_word), .b_word(b_word), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done),
        .eq(eq), .gt(gt), .lt(lt)
    );

    seq_word_comparator #(.WORD_W(WORD_W), .NUM_WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .lsw_first(lsw1),
        .a_word(a1), .b_word(b1), .in_valid(valid1),
        .in_ready(ready1), .busy(busy1), .done(done1),
        .eq(eq1), .gt(gt1), .lt(lt1)
    );

    // Whole-operand reference: {eq, gt, lt} of two unsigned 256-bit numbers.
    function automatic logic [2:0] refModel(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        return {a == b, a > b, a < b};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Streams one compare; cycle 0 is the cycle start is high.
    task automatic applyStimulus(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                 input bit lsw, input int gap_start, input int gap_len,
                                 input bit mid_start, input bit chain, input bit next_lsw,
                                 output int done_cycle, output int pairs);
        int cycle;
        int idx;
        done_cycle = -1;
        pairs = 0;
        cycle = 0;
        if (!pre_started) begin
            @(posedge clk); #1;
            start = 1'b1;
            lsw_first = lsw;
            in_valid = 1'b0;
        end
        pre_started = 0;
        while (cycle < 60 && done_cycle < 0) begin
            @(posedge clk); #1;
            cycle++;
            start = 1'b0;
            lsw_first = ~lsw;
            if (cycle == 1)
                checkOutput("compare_entry", int'({in_ready, busy, done, eq, gt, lt}), 6'b110000);
            if (done) begin
                done_cycle = cycle;
                checkOutput("done_flags", int'({in_ready, busy}), 0);
                in_valid = 1'b0;
                if (chain) begin
                    start = 1'b1;
                    lsw_first = next_lsw;
                    pre_started = 1;
                end
            end else begin
                if (mid_start && cycle == 3)
                    start = 1'b1;
                in_valid = !(cycle >= gap_start && cycle < gap_start + gap_len);
                if (pairs < NUM_WORDS)
                    idx = lsw ? pairs : NUM_WORDS - 1 - pairs;
                else
                    idx = 0;
                a_word = a[idx*WORD_W +: WORD_W];
                b_word = b[idx*WORD_W +: WORD_W];
                if (in_valid && in_ready)
                    pairs++;
            end
        end
        if (done_cycle < 0)
            checkOutput("done_timeout", 0, 1);
    endtask

    task automatic runOne(input vec_t v, input bit mid_start, input bit chain,
                          input bit next_lsw, input bit check_hold);
        int dc;
        int pr;
        applyStimulus(v.a, v.b, v.lsw, v.gap_start, v.gap_len, mid_start, chain, next_lsw, dc, pr);
        checkOutput("done_cycle", dc, v.exp_done);
        checkOutput("pairs_consumed", pr, NUM_WORDS);
        checkOutput("result", int'({eq, gt, lt}), int'(v.exp_res));
        if (check_hold) begin
            @(posedge clk); #1;
            checkOutput("result_hold", int'({done, eq, gt, lt}), int'({1'b0, v.exp_res}));
        end
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        int acc;
        int guard;
        bit saw_done;
        int mode;

        vecs[0].a = {4{64'h0123456789ABCDEF}};
        vecs[0].b = vecs[0].a;
        vecs[0].lsw = 0; vecs[0].gap_start = 0; vecs[0].gap_len = 0;
        vecs[0].exp_res = 3'b100; vecs[0].exp_done = 9;

        vecs[1].a = '0; vecs[1].b = '0;
        vecs[1].a[5*WORD_W +: WORD_W] = 32'h00000005;
        vecs[1].b[5*WORD_W +: WORD_W] = 32'h00000009;
        vecs[1].a[2*WORD_W +: WORD_W] = 32'h0000FFFF;
        vecs[1].b[2*WORD_W +: WORD_W] = 32'h00000001;
        vecs[1].lsw = 0; vecs[1].gap_start = 0; vecs[1].gap_len = 0;
        vecs[1].exp_res = 3'b001; vecs[1].exp_done = 9;

        vecs[2] = vecs[1];
        vecs[2].lsw = 1;

        vecs[3].a = {4{64'h0123456789ABCDEF}};
        vecs[3].b = vecs[3].a;
        vecs[3].b[3*WORD_W +: WORD_W] = 32'h0;
        vecs[3].lsw = 0; vecs[3].gap_start = 4; vecs[3].gap_len = 3;
        vecs[3].exp_res = 3'b010; vecs[3].exp_done = 12;

        vecs[4].a = '0; vecs[4].b = '0;
        vecs[4].a[WORD_W-1:0] = 32'h80000000;
        vecs[4].b[WORD_W-1:0] = 32'h7FFFFFFF;
        vecs[4].lsw = 1; vecs[4].gap_start = 0; vecs[4].gap_len = 0;
        vecs[4].exp_res = 3'b010; vecs[4].exp_done = 9;

        vecs[5].a = '1; vecs[5].b = '0;
        vecs[5].a[7*WORD_W +: WORD_W] = 32'h0;
        vecs[5].b[7*WORD_W +: WORD_W] = 32'hFFFFFFFF;
        vecs[5].lsw = 1; vecs[5].gap_start = 0; vecs[5].gap_len = 0;
        vecs[5].exp_res = 3'b001; vecs[5].exp_done = 9;

        @(posedge clk); #1;
        checkOutput("reset_state", int'({in_ready, busy, done, eq, gt, lt}), 0);
        checkOutput("reset_state_n1", int'({ready1, busy1, done1, eq1, gt1, lt1}), 0);
        #12 rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            runOne(vecs[i], 0, 0, 0, 1);

        // Back-to-back: second start lands in the first compare's DONE cycle.
        runOne(vecs[1], 0, 1, 1, 0);
        runOne(vecs[2], 1, 0, 0, 1);

        for (int r = 0; r < 20; r++) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                rv.a[w*WORD_W +: WORD_W] = $urandom();
                rv.b[w*WORD_W +: WORD_W] = $urandom();
            end
            mode = $urandom_range(0, 2);
            if (mode != 0) rv.b = rv.a;
            if (mode == 2) rv.b[$urandom_range(0, NUM_WORDS-1)*WORD_W +: WORD_W] = $urandom();
            rv.lsw = bit'($urandom_range(0, 1));
            rv.gap_len = $urandom_range(0, 3);
            rv.gap_start = $urandom_range(2, 6);
            rv.exp_res = refModel(rv.a, rv.b);
            rv.exp_done = NUM_WORDS + 1 + rv.gap_len;
            runOne(rv, r[0], 0, 0, 1);
        end

        // Reset in the middle of a compare.
        @(posedge clk); #1;
        start = 1'b1; lsw_first = 1'b0; in_valid = 1'b0;
        acc = 0; guard = 0;
        while (acc < 4 && guard < 20) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b1;
            a_word = $urandom(); b_word = $urandom();
            if (in_ready) acc++;
            guard++;
        end
        @(posedge clk); #1;
        checkOutput("busy_before_reset", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", int'({in_ready, busy, done, eq, gt, lt}), 0);
        saw_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
            if (c == 3) rst_n = 1'b1;
        end
        checkOutput("no_done_after_reset", int'(saw_done), 0);
        checkOutput("idle_after_reset", int'({in_ready, busy}), 0);
        in_valid = 1'b0;

        // Single-word variant goes straight to DONE after one pair.
        @(posedge clk); #1;
        start1 = 1'b1; valid1 = 1'b1; a1 = 32'd3; b1 = 32'd2;
        @(posedge clk); #1;
        start1 = 1'b0;
        checkOutput("n1_cycle1", int'({ready1, busy1, done1}), 3'b110);
        @(posedge clk); #1;
        valid1 = 1'b0;
        checkOutput("n1_cycle2", int'({done1, eq1, gt1, lt1}), 4'b1010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
